// File: rtl/foutto1_pkg.sv
// foutto1_pkg: shared constants and types for the foutto1_mux block.
// Lane count, select width and histogram counter sizing live here so the
// top, the select core and the bench all agree on them.
package foutto1_pkg;

  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;
  localparam int HIST_W = 8;

  localparam logic [HIST_W-1:0] HIST_MAX = 8'd255;

  typedef logic [SEL_W-1:0] sel_t;

  // Saturating increment for the histogram counters; sticks at HIST_MAX.
  function automatic logic [HIST_W-1:0] sat_inc(input logic [HIST_W-1:0] v);
    return (v == HIST_MAX) ? v : HIST_W'(v + 1'b1);
  endfunction

endpackage

// File: rtl/foutto1_mux_core.sv
// mux4_core: purely combinational 4:1 lane select, W bits per lane.
// Lane k occupies i[k*W +: W]. An unknown select yields X on y because
// a packed-array read with an X index returns X in simulation.
module mux4_core
  import foutto1_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [NUM_IN*W-1:0] i,
  input  sel_t                s,
  output logic [W-1:0]        y
);

  logic [NUM_IN-1:0][W-1:0] lanes;

  // Re-view the flat input bus as an array of lanes, lane 0 in the LSBs.
  always_comb begin
    lanes = i;
  end

  // Selected lane, zero latency.
  always_comb begin
    y = lanes[s];
  end

endmodule

// File: rtl/foutto1_mux.sv
// foutto1_mux: 4-input selector with a combinational output (y), a
// registered copy with capture enable (y_q) and a change pulse (chg).
// Optional build macro FOUTTO1_HIST_EN adds a per-lane 8-bit saturating
// selection histogram on output hist. y, y_q and chg are the same in both
// builds.
module foutto1_mux
  import foutto1_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IN*W-1:0] i,
  input  logic [SEL_W-1:0]    s,
  input  logic                en,
  output logic [W-1:0]        y,
  output logic [W-1:0]        y_q,
`ifdef FOUTTO1_HIST_EN
  output logic [NUM_IN*HIST_W-1:0] hist,
`endif
  output logic                chg
);

  sel_t         sel;
  logic [W-1:0] y_sel;
  logic         differs;

  // Select is passed through as the package type for the core.
  always_comb begin
    sel = sel_t'(s);
  end

  mux4_core #(.W(W)) u_core (
    .i (i),
    .s (sel),
    .y (y_sel)
  );

  // Glue-logic output is the raw core result; reset does not touch it.
  always_comb begin
    y       = y_sel;
    differs = (y_sel != y_q);
  end

  // Registered copy: capture on en, flag a capture that changed the value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= RST_VAL;
      chg <= 1'b0;
    end else begin
      chg <= en & differs;
      if (en) y_q <= y_sel;
    end
  end

`ifdef FOUTTO1_HIST_EN
  logic [NUM_IN-1:0][HIST_W-1:0] hist_cnt;

  // One saturating counter per lane, bumped when that lane is captured.
  for (genvar k = 0; k < NUM_IN; k++) begin : g_hist
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        hist_cnt[k] <= '0;
      else if (en && (sel == sel_t'(k)))
        hist_cnt[k] <= sat_inc(hist_cnt[k]);
    end
  end

  // Counter k lands in hist[8k +: 8].
  always_comb begin
    hist = hist_cnt;
  end
`endif

endmodule

// File: tb/tb_foutto1_mux.sv
// tb_foutto1_mux: directed self-checking bench for foutto1_mux (W=1).
// With FOUTTO1_HIST_EN defined it also exercises the histogram.
`timescale 1ns/1ps
module tb_foutto1_mux;

  logic       clk;
  logic       rst_n;
  logic [3:0] i;
  logic [1:0] s;
  logic       en;
  logic       y;
  logic       y_q;
  logic       chg;
`ifdef FOUTTO1_HIST_EN
  logic [31:0] hist;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  foutto1_mux #(.W(1), .RST_VAL(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .s     (s),
    .en    (en),
    .y     (y),
    .y_q   (y_q),
`ifdef FOUTTO1_HIST_EN
    .hist  (hist),
`endif
    .chg   (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] iv;

    // Reset state
    rst_n = 1'b0; i = 4'd0; s = 2'd0; en = 1'b0;
    #100;
    check("rst_y",   32'(y),   32'd0);
    check("rst_y_q", 32'(y_q), 32'd0);
    check("rst_chg", 32'(chg), 32'd0);
`ifdef FOUTTO1_HIST_EN
    check("rst_hist", hist, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Exhaustive combinational sweep, en=0 so y_q must hold
    for (int ii = 0; ii < 16; ii++) begin
      for (int ss = 0; ss < 4; ss++) begin
        iv = 4'(ii);
        i = iv; s = 2'(ss);
        #1;
        check($sformatf("sweep_i%0d_s%0d", ii, ss), 32'(y), 32'(iv[ss]));
        #9;
      end
    end
    check("sweep_y_q_hold", 32'(y_q), 32'd0);
    check("sweep_chg",      32'(chg), 32'd0);

    // Spot checks
    i = 4'b0101; s = 2'd2; #1; check("spot_0101_s2", 32'(y), 32'd1);
    i = 4'b0101; s = 2'd1; #1; check("spot_0101_s1", 32'(y), 32'd0);
    i = 4'b1000; s = 2'd3; #1; check("spot_1000_s3", 32'(y), 32'd1);
    i = 4'b1000; s = 2'd0; #1; check("spot_1000_s0", 32'(y), 32'd0);

    // Capture with enable: change pulse then quiet
    @(negedge clk); i = 4'b0100; s = 2'd2; en = 1'b1;
    @(posedge clk); #1;
    check("cap_y_q", 32'(y_q), 32'd1);
    check("cap_chg", 32'(chg), 32'd1);
    @(posedge clk); #1;
    check("cap2_y_q", 32'(y_q), 32'd1);
    check("cap2_chg", 32'(chg), 32'd0);

    // Enable off: y follows inputs, y_q holds, no pulse
    @(negedge clk); en = 1'b0; i = 4'b0000; #1;
    check("hold_y",   32'(y),   32'd0);
    check("hold_y_q", 32'(y_q), 32'd1);
    @(posedge clk); #1;
    check("hold2_y_q", 32'(y_q), 32'd1);
    check("hold2_chg", 32'(chg), 32'd0);

    // Captured value differs with en=0 gated edge, then en=1 changes to 0
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    check("fall_y_q", 32'(y_q), 32'd0);
    check("fall_chg", 32'(chg), 32'd1);

    // Re-raise to 1, then assert reset between edges
    @(negedge clk); i = 4'b0001; s = 2'd0;
    @(posedge clk); #1;
    check("rise_y_q", 32'(y_q), 32'd1);
    check("rise_chg", 32'(chg), 32'd1);
    @(negedge clk); en = 1'b0; #2;
    rst_n = 1'b0; #1;
    check("async_y_q", 32'(y_q), 32'd0);
    check("async_chg", 32'(chg), 32'd0);
    i = 4'b0010; s = 2'd1; #1;
    check("async_y_track1", 32'(y), 32'd1);
    s = 2'd3; #1;
    check("async_y_track0", 32'(y), 32'd0);
    @(posedge clk); #1;
    check("async_hold_y_q", 32'(y_q), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Capture of an equal value does not pulse chg
    @(negedge clk); en = 1'b1; i = 4'b0000; s = 2'd2;
    @(posedge clk); #1;
    check("same_y_q", 32'(y_q), 32'd0);
    check("same_chg", 32'(chg), 32'd0);
    @(negedge clk); en = 1'b0;

`ifdef FOUTTO1_HIST_EN
    // Histogram: reset, count a few on lane 0, then saturate lane 3
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("hist_clear0", hist, 32'd0);
    @(negedge clk); en = 1'b1; s = 2'd0;
    repeat (3) @(negedge clk);
    check("hist_lane0_3", hist, 32'h0000_0003);
    @(negedge clk); rst_n = 1'b0; #1;
    check("hist_clear1", hist, 32'd0);
    @(negedge clk); rst_n = 1'b1; s = 2'd3;
    repeat (300) @(negedge clk);
    check("hist_sat", hist, 32'hFF00_0000);
    en = 1'b0;
    rst_n = 1'b0; #1;
    check("hist_clear2", hist, 32'd0);
    @(negedge clk); rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
